// File: rtl/gamecontrol_pkg.sv
// Shared game-control definitions: scheduler states, playfield extents and coordinate widths.
package gamecontrol_pkg;

    localparam int HOR_FIELD = 1279;
    localparam int VER_FIELD = 1023;
    localparam int X_W       = 12;
    localparam int Y_W       = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        SPAWN    = 2'd2,
        COOLDOWN = 2'd3
    } sched_state_t;

endpackage

// File: rtl/slot_picker.sv
// Lowest-index free-slot priority encoder over the bullet occupancy vector.
module slot_picker #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3
) (
    input  logic [NUM_SLOTS-1:0] busy,
    output logic                 free_any,
    output logic [SLOT_W-1:0]    free_idx
);

    // Scan high to low so the last hit, the lowest free index, wins.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/bullet_scheduler.sv
// Frame-synchronous bullet scheduler: one fire request at a time, allocated on calc,
// spawned into the lowest free slot, followed by a per-frame cooldown.
module bullet_scheduler
    import gamecontrol_pkg::*;
#(
    parameter int NUM_SLOTS       = 8,
    parameter int SLOT_W          = 3,
    parameter int COOLDOWN_FRAMES = 10,
    parameter int HOR_FIELD       = gamecontrol_pkg::HOR_FIELD,
    parameter int X_OFFSET        = 32,
    parameter int Y_OFFSET        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fire,
    input  logic [11:0]          ship_x,
    input  logic [10:0]          ship_y,
    input  logic                 calc,
    input  logic [NUM_SLOTS-1:0] slot_release,
    output logic                 spawn_valid,
    output logic [SLOT_W-1:0]    spawn_slot,
    output logic [11:0]          spawn_x,
    output logic [10:0]          spawn_y,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic                 pending,
    output logic [15:0]          shots_fired
);

    sched_state_t state, state_next;
    logic [7:0]   cool_cnt, cool_next;
    logic         fire_s1, fire_s2, fire_s3;
    logic         fire_rise;
    logic         free_any;
    logic [SLOT_W-1:0]    free_idx;
    logic                 capture;
    logic [12:0]          x_sum;
    logic [11:0]          x_launch;
    logic [10:0]          y_launch;
    logic [NUM_SLOTS-1:0] set_mask;
    logic [NUM_SLOTS-1:0] busy_next;

    // fire is asynchronous: two flops to resolve, a third to find the rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            fire_s1 <= 1'b0;
            fire_s2 <= 1'b0;
            fire_s3 <= 1'b0;
        end else begin
            fire_s1 <= fire;
            fire_s2 <= fire_s1;
            fire_s3 <= fire_s2;
        end
    end

    assign fire_rise = fire_s2 & ~fire_s3;

    slot_picker #(
        .NUM_SLOTS(NUM_SLOTS),
        .SLOT_W   (SLOT_W)
    ) u_picker (
        .busy    (slot_busy),
        .free_any(free_any),
        .free_idx(free_idx)
    );

    assign x_sum    = {1'b0, ship_x} + 13'(X_OFFSET);
    assign x_launch = (x_sum > 13'(HOR_FIELD)) ? 12'(HOR_FIELD) : x_sum[11:0];
    assign y_launch = (ship_y < 11'(Y_OFFSET)) ? 11'd0 : ship_y - 11'(Y_OFFSET);

    assign capture = (state == ARMED) && calc && free_any;

    always_comb begin
        state_next = state;
        cool_next  = cool_cnt;
        case (state)
            IDLE: begin
                if (fire_rise) state_next = ARMED;
            end
            ARMED: begin
                if (capture) state_next = SPAWN;
            end
            SPAWN: begin
                cool_next  = 8'(COOLDOWN_FRAMES);
                state_next = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
            end
            COOLDOWN: begin
                if (calc) begin
                    cool_next = cool_cnt - 8'd1;
                    if (cool_cnt <= 8'd1) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A set in the spawn cycle is applied after the release mask so a conflicting release loses.
    always_comb begin
        set_mask = '0;
        if (state == SPAWN) set_mask = NUM_SLOTS'(1) << spawn_slot;
        busy_next = (slot_busy & ~slot_release) | set_mask;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cool_cnt    <= '0;
            spawn_slot  <= '0;
            spawn_x     <= '0;
            spawn_y     <= '0;
            slot_busy   <= '0;
            shots_fired <= '0;
        end else begin
            state     <= state_next;
            cool_cnt  <= cool_next;
            slot_busy <= busy_next;
            if (capture) begin
                spawn_slot <= free_idx;
                spawn_x    <= x_launch;
                spawn_y    <= y_launch;
            end
            if (state == SPAWN) shots_fired <= shots_fired + 16'd1;
        end
    end

    assign spawn_valid = (state == SPAWN);
    assign pending     = (state == ARMED);

endmodule

// File: tb/tb_bullet_scheduler.sv
// Bench for bullet_scheduler: directed scenarios plus random traffic, checked every cycle
// against a request/cooldown/occupancy model.
module tb_bullet_scheduler;

    localparam int NS = 8;
    localparam int CD = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fire  = 1'b0;
    logic        calc  = 1'b0;
    logic [11:0] ship_x = '0;
    logic [10:0] ship_y = '0;
    logic [NS-1:0] slot_release = '0;
    logic        spawn_valid;
    logic [2:0]  spawn_slot;
    logic [11:0] spawn_x;
    logic [10:0] spawn_y;
    logic [NS-1:0] slot_busy;
    logic        pending;
    logic [15:0] shots_fired;

    int tests = 0;
    int fails = 0;

    bullet_scheduler #(.NUM_SLOTS(NS), .SLOT_W(3), .COOLDOWN_FRAMES(CD)) dut (
        .clock(clock), .reset(reset), .fire(fire), .ship_x(ship_x), .ship_y(ship_y),
        .calc(calc), .slot_release(slot_release), .spawn_valid(spawn_valid),
        .spawn_slot(spawn_slot), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .slot_busy(slot_busy), .pending(pending), .shots_fired(shots_fired)
    );

    always #5 clock = ~clock;

    // Model: request waiting, spawn this cycle, frames of cooldown left, occupancy.
    bit          m_pend, m_spawn;
    int          m_cool;
    logic [NS-1:0] m_busy;
    logic [15:0] m_shots;
    logic [2:0]  m_slot;
    logic [11:0] m_x;
    logic [10:0] m_y;
    bit          seen [3];   // fire as seen on the last three clock edges, newest first

    task automatic model_step();
        bit rise;
        logic [NS-1:0] nb;
        int xs;
        if (reset) begin
            m_pend = 0; m_spawn = 0; m_cool = 0; m_busy = '0; m_shots = '0;
            m_slot = '0; m_x = '0; m_y = '0;
            seen[0] = 0; seen[1] = 0; seen[2] = 0;
            return;
        end
        // A request is recognised once a high sample follows a low one, two edges after sampling.
        rise = seen[1] && !seen[2];
        seen[2] = seen[1]; seen[1] = seen[0]; seen[0] = fire;
        nb = m_busy & ~slot_release;
        if (m_spawn) begin
            nb[m_slot] = 1'b1;
            m_shots = m_shots + 16'd1;
            m_spawn = 0;
            m_cool  = CD;
        end else if (m_pend) begin
            if (calc && m_busy != '1) begin
                for (int i = NS - 1; i >= 0; i--) if (!m_busy[i]) m_slot = 3'(i);
                xs  = int'(ship_x) + 32;
                m_x = (xs > 1279) ? 12'd1279 : 12'(xs);
                m_y = (int'(ship_y) < 8) ? 11'd0 : 11'(int'(ship_y) - 8);
                m_spawn = 1;
                m_pend  = 0;
            end
        end else if (m_cool > 0) begin
            if (calc) m_cool = m_cool - 1;
        end else if (rise) begin
            m_pend = 1;
        end
        m_busy = nb;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        chk("cycle_outputs",
            {spawn_valid, spawn_slot, spawn_x, spawn_y, slot_busy, pending, shots_fired},
            {m_spawn, m_slot, m_x, m_y, m_busy, m_pend, m_shots});
    end

    int spawn_cnt = 0;
    logic [2:0]  last_slot;
    logic [11:0] last_x;
    logic [10:0] last_y;
    always @(negedge clock) begin
        if (spawn_valid === 1'b1) begin
            spawn_cnt++;
            last_slot = spawn_slot;
            last_x = spawn_x;
            last_y = spawn_y;
        end
    end

    task automatic tick();
        model_step();
        @(negedge clock);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            calc = 1'b1; tick();
            calc = 1'b0; repeat (3) tick();
        end
    endtask

    task automatic pulse();
        fire = 1'b1; tick();
        fire = 1'b0; tick();
    endtask

    int base;

    initial begin
        // Reset state
        reset = 1'b1; tick(); tick();
        reset = 1'b0; tick();
        chk("reset_outputs", {spawn_valid, spawn_slot, spawn_x, spawn_y, slot_busy, pending, shots_fired}, 64'd0);

        // First spawn: slot 0 at (132, 492)
        fire = 1'b1; tick(); fire = 1'b0;
        repeat (9) tick();
        chk("armed_after_edge", pending, 1);
        ship_x = 12'd100; ship_y = 11'd500;
        calc = 1'b1; tick(); calc = 1'b0;
        chk("first_spawn_valid", spawn_valid, 1);
        chk("first_spawn_slot", spawn_slot, 0);
        chk("first_spawn_x", spawn_x, 132);
        chk("first_spawn_y", spawn_y, 492);
        tick();
        chk("first_spawn_one_cycle", spawn_valid, 0);
        chk("first_busy", slot_busy, 8'h01);
        chk("first_shots", shots_fired, 1);

        // Held fire gives exactly one spawn
        frames(11);
        base = spawn_cnt;
        fire = 1'b1; frames(50); fire = 1'b0;
        chk("held_fire_spawns", spawn_cnt - base, 1);
        chk("held_fire_slot", last_slot, 1);

        // Edges during cooldown are ignored
        frames(11); pulse(); frames(2);
        chk("slot2_spawn", last_slot, 2);
        base = spawn_cnt;
        repeat (5) begin pulse(); frames(1); end
        chk("cooldown_ignores_fire", spawn_cnt - base, 0);
        frames(6); pulse(); frames(2);
        chk("after_cooldown_spawns", spawn_cnt - base, 1);
        chk("after_cooldown_slot", last_slot, 3);

        // Fill the pool, then a request waits for a release
        repeat (4) begin frames(11); pulse(); frames(2); end
        chk("pool_full", slot_busy, 8'hFF);
        frames(11);
        base = spawn_cnt;
        pulse(); frames(3);
        chk("held_when_full_pending", pending, 1);
        chk("held_when_full_nospawn", spawn_cnt - base, 0);
        slot_release = 8'h20; tick(); slot_release = '0;
        frames(1);
        chk("release_then_spawn", spawn_cnt - base, 1);
        chk("release_slot5", last_slot, 5);

        // Coordinate clamping
        frames(11);
        slot_release = 8'h01; tick(); slot_release = '0;
        ship_x = 12'd1270; ship_y = 11'd3;
        pulse(); frames(2);
        chk("clamp_x", last_x, 1279);
        chk("clamp_y", last_y, 0);

        // Release in the spawn cycle of another slot
        slot_release = 8'h08; tick(); slot_release = '0;
        frames(11);
        pulse(); tick(); tick();
        calc = 1'b1; tick(); calc = 1'b0;
        chk("spawn_into_3", {spawn_valid, spawn_slot}, {1'b1, 3'd3});
        slot_release = 8'h04; tick(); slot_release = '0;
        chk("release_and_set", slot_busy, 8'hFB);

        // Reset while armed with a full pool
        frames(11); pulse(); frames(2);
        chk("refill", slot_busy, 8'hFF);
        frames(11); pulse(); tick();
        chk("armed_full", pending, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midreset_outputs", {spawn_valid, spawn_slot, spawn_x, spawn_y, slot_busy, pending, shots_fired}, 64'd0);
        ship_x = 12'd0; ship_y = 11'd20;
        pulse(); frames(2);
        chk("post_reset_slot", last_slot, 0);
        chk("post_reset_shots", shots_fired, 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) fire = ~fire;
            calc = !calc && ($urandom_range(0, 3) == 0);
            slot_release = ($urandom_range(0, 5) == 0) ? NS'(1) << $urandom_range(0, NS - 1) : '0;
            if ($urandom_range(0, 15) == 0) begin
                ship_x = 12'($urandom);
                ship_y = 11'($urandom);
            end
            reset = ($urandom_range(0, 699) == 0);
            tick();
        end
        reset = 1'b0; calc = 1'b0; fire = 1'b0; slot_release = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
